// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the axi_interconnect read path.
// Response codes, arbiter FSM encoding, default address map.
package axi_ic_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DECERR
  } rd_state_e;

  localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_S1_BASE = 32'h9000_0000;
  localparam logic [31:0] DEF_MASK    = 32'hF000_0000;

  localparam logic [63:0] DEF_S_BASE =
    {DEF_S1_BASE, DEF_S0_BASE};
  localparam logic [63:0] DEF_S_MASK =
    {DEF_MASK, DEF_MASK};

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Read-path bundle between masters, arbiter and slaves.
// slave: arbiter view; master: view of the attached agents.
interface axi_rd_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);

  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [NUM_MASTERS*3-1:0]          M_AXI_ARPROT;
  logic [NUM_MASTERS-1:0]            M_AXI_ARVALID;
  logic [NUM_MASTERS-1:0]            M_AXI_ARREADY;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [NUM_MASTERS*2-1:0]          M_AXI_RRESP;
  logic [NUM_MASTERS-1:0]            M_AXI_RVALID;
  logic [NUM_MASTERS-1:0]            M_AXI_RREADY;

  logic [NUM_SLAVES*ADDR_WIDTH-1:0]  S_AXI_ARADDR;
  logic [NUM_SLAVES*3-1:0]           S_AXI_ARPROT;
  logic [NUM_SLAVES-1:0]             S_AXI_ARVALID;
  logic [NUM_SLAVES-1:0]             S_AXI_ARREADY;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]  S_AXI_RDATA;
  logic [NUM_SLAVES*2-1:0]           S_AXI_RRESP;
  logic [NUM_SLAVES-1:0]             S_AXI_RVALID;
  logic [NUM_SLAVES-1:0]             S_AXI_RREADY;

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA,
    output M_AXI_RRESP, M_AXI_RVALID,
    output S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RDATA,
    input  S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA,
    input  M_AXI_RRESP, M_AXI_RVALID,
    input  S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RDATA,
    output S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts one above the previous winner and wraps.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int   i;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    i         = 0;
    for (int k = 1; k <= N; k++) begin
      i = (int'(last) + k) % N;
      if (!found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI4-Lite read arbiter/router: round-robin masters, address
// decode to slaves, local DECERR, one transaction in flight.
module axi_rd_arbiter
  import axi_ic_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] S_BASE = DEF_S_BASE,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] S_MASK = DEF_S_MASK
) (
  input logic             ACLK,
  input logic             ARESETN,
  axi_rd_arbiter_if.slave bus
);

  localparam int AW  = ADDR_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  rd_state_e state, nxt;

  logic [MIW-1:0]         last, gnt, win_idx;
  logic [SIW-1:0]         slv, dec_idx;
  logic [AW-1:0]          addr, win_addr;
  logic [2:0]             prot, win_prot;
  logic [NUM_MASTERS-1:0] win;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   dec_ok, accept, done;

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req       (bus.M_AXI_ARVALID),
    .last      (last),
    .grant     (win),
    .grant_idx (win_idx)
  );

  assign win_addr = bus.M_AXI_ARADDR[int'(win_idx)*AW +: AW];
  assign win_prot = bus.M_AXI_ARPROT[int'(win_idx)*3 +: 3];

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_dec
    assign hit[s] =
      (win_addr & S_MASK[s*AW +: AW]) == S_BASE[s*AW +: AW];
  end

  // Walk downward so the lowest matching slave wins
  always_comb begin
    dec_ok  = 1'b0;
    dec_idx = '0;
    for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
      if (hit[s]) begin
        dec_ok  = 1'b1;
        dec_idx = SIW'(s);
      end
    end
  end

  assign accept = (state == ST_IDLE) && ARESETN &&
                  (|bus.M_AXI_ARVALID);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= ST_IDLE;
      last  <= MIW'(NUM_MASTERS - 1);
      gnt   <= '0;
      slv   <= '0;
      addr  <= '0;
      prot  <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        gnt  <= win_idx;
        slv  <= dec_idx;
        addr <= win_addr;
        prot <= win_prot;
      end
      if (done) last <= gnt;
    end
  end

  always_comb begin
    nxt               = state;
    done              = 1'b0;
    bus.M_AXI_ARREADY = '0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = '0;
    bus.M_AXI_RVALID  = '0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = '0;
    bus.S_AXI_RREADY  = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          bus.M_AXI_ARREADY = win;
          nxt = dec_ok ? ST_ADDR : ST_DECERR;
        end
      end
      ST_ADDR: begin
        bus.S_AXI_ARVALID[slv] = 1'b1;
        bus.S_AXI_ARADDR[int'(slv)*AW +: AW] = addr;
        bus.S_AXI_ARPROT[int'(slv)*3 +: 3]   = prot;
        if (bus.S_AXI_ARREADY[slv]) nxt = ST_DATA;
      end
      ST_DATA: begin
        bus.M_AXI_RVALID[gnt] = bus.S_AXI_RVALID[slv];
        bus.M_AXI_RDATA[int'(gnt)*DW +: DW] =
          bus.S_AXI_RDATA[int'(slv)*DW +: DW];
        bus.M_AXI_RRESP[int'(gnt)*2 +: 2] =
          bus.S_AXI_RRESP[int'(slv)*2 +: 2];
        bus.S_AXI_RREADY[slv] = bus.M_AXI_RREADY[gnt];
        if (bus.S_AXI_RVALID[slv] && bus.M_AXI_RREADY[gnt]) begin
          nxt  = ST_IDLE;
          done = 1'b1;
        end
      end
      ST_DECERR: begin
        bus.M_AXI_RVALID[gnt] = 1'b1;
        bus.M_AXI_RRESP[int'(gnt)*2 +: 2] = RESP_DECERR;
        if (bus.M_AXI_RREADY[gnt]) begin
          nxt  = ST_IDLE;
          done = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed reads, decode
// error, round robin, backpressure and mid-transaction reset.
module tb_axi_rd_arbiter;
  import axi_ic_pkg::*;

  typedef struct {
    int          s;
    logic [31:0] addr;
    logic [2:0]  prot;
  } ar_exp_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic aclk;
  logic rst_n;
  int   total;
  int   bad;
  int   out_cnt;

  ar_exp_t exp_ar[$];
  r_exp_t  exp_r[$];

  axi_rd_arbiter_if #(
    .NUM_MASTERS(2), .NUM_SLAVES(2),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) bus ();

  axi_rd_arbiter dut (
    .ACLK    (aclk),
    .ARESETN (rst_n),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Slave model: a slave answers one cycle after its AR handshake
  logic [1:0] pend, arhs, rhs;
  initial begin
    pend = '0;
    bus.S_AXI_RVALID = '0;
    forever begin
      @(negedge aclk);
      arhs = bus.S_AXI_ARVALID & bus.S_AXI_ARREADY;
      rhs  = bus.S_AXI_RVALID & bus.S_AXI_RREADY;
      @(posedge aclk);
      #1;
      if (!rst_n) pend = '0;
      else pend = (pend & ~rhs) | arhs;
      bus.S_AXI_RVALID = pend;
    end
  end

  // Monitor: pops the scoreboard on every handshake it observes
  ar_exp_t ea;
  r_exp_t  er;
  always @(negedge aclk) begin
    if (!rst_n) begin
      out_cnt = 0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (bus.M_AXI_ARVALID[m] && bus.M_AXI_ARREADY[m]) begin
          chk("one_outstanding", out_cnt, 0);
          out_cnt++;
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (bus.S_AXI_ARVALID[s] && bus.S_AXI_ARREADY[s]) begin
          if (exp_ar.size() == 0) begin
            chk("ar_unexpected", 1, 0);
          end else begin
            ea = exp_ar.pop_front();
            chk("ar_slave", s, ea.s);
            chk("ar_addr", bus.S_AXI_ARADDR[s*32 +: 32], ea.addr);
            chk("ar_prot", bus.S_AXI_ARPROT[s*3 +: 3], ea.prot);
          end
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (bus.M_AXI_RVALID[m] && bus.M_AXI_RREADY[m]) begin
          out_cnt--;
          if (exp_r.size() == 0) begin
            chk("r_unexpected", 1, 0);
          end else begin
            er = exp_r.pop_front();
            chk("r_master", m, er.m);
            chk("r_data", bus.M_AXI_RDATA[m*32 +: 32], er.data);
            chk("r_resp", bus.M_AXI_RRESP[m*2 +: 2], er.resp);
          end
        end
      end
    end
  end

  task automatic wait_grant(input int m);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge aclk);
      if (bus.M_AXI_ARREADY[m]) ok = 1'b1;
      n++;
    end
    @(posedge aclk);
    #1;
    chk("grant", ok, 1);
  endtask

  task automatic issue(input int m, input logic [31:0] a,
                       input logic [2:0] p);
    bus.M_AXI_ARADDR[m*32 +: 32] = a;
    bus.M_AXI_ARPROT[m*3 +: 3]   = p;
    bus.M_AXI_ARVALID[m]         = 1'b1;
    wait_grant(m);
    bus.M_AXI_ARVALID[m] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_ar.size() != 0) && n < 60) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    chk("drain", exp_r.size() + exp_ar.size(), 0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_arready"}, bus.M_AXI_ARREADY, 0);
    chk({nm, "_rvalid"}, bus.M_AXI_RVALID, 0);
    chk({nm, "_rdata"}, bus.M_AXI_RDATA, 0);
    chk({nm, "_s_arvalid"}, bus.S_AXI_ARVALID, 0);
    chk({nm, "_s_araddr"}, bus.S_AXI_ARADDR, 0);
    chk({nm, "_s_rready"}, bus.S_AXI_RREADY, 0);
  endtask

  logic [31:0] d0, d1;

  initial begin
    total = 0;
    bad   = 0;
    d0    = 32'hDEAD_BEEF;
    d1    = 32'h1234_5678;
    rst_n = 1'b0;
    bus.M_AXI_ARADDR  = {32'h9000_0000, 32'h0000_1000};
    bus.M_AXI_ARPROT  = '0;
    bus.M_AXI_ARVALID = 2'b11;
    bus.M_AXI_RREADY  = 2'b11;
    bus.S_AXI_ARREADY = 2'b11;
    bus.S_AXI_RDATA   = {d1, d0};
    bus.S_AXI_RRESP   = {RESP_SLVERR, RESP_OKAY};

    #12;
    chk_quiet("reset");
    bus.M_AXI_ARVALID = 2'b00;
    @(posedge aclk);
    #2 rst_n = 1'b1;
    @(posedge aclk);
    #1;

    // single read to slave 0, minimum 3-cycle transaction
    exp_ar.push_back('{0, 32'h0000_1000, 3'd1});
    exp_r.push_back('{0, d0, RESP_OKAY});
    issue(0, 32'h0000_1000, 3'd1);
    chk("s0_arvalid", bus.S_AXI_ARVALID, 2'b01);
    chk("s0_araddr", bus.S_AXI_ARADDR[31:0], 32'h0000_1000);
    @(posedge aclk);
    #2;
    chk("s0_rvalid_t2", bus.M_AXI_RVALID, 2'b01);
    drain();

    // single read to slave 1
    exp_ar.push_back('{1, 32'h9000_0000, 3'd5});
    exp_r.push_back('{0, d1, RESP_SLVERR});
    issue(0, 32'h9000_0000, 3'd5);
    chk("s1_arvalid", bus.S_AXI_ARVALID, 2'b10);
    chk("s1_araddr", bus.S_AXI_ARADDR[63:32], 32'h9000_0000);
    drain();

    // unmapped address
    exp_r.push_back('{0, 32'h0, RESP_DECERR});
    issue(0, 32'h5000_0000, 3'd0);
    chk("dec_rvalid", bus.M_AXI_RVALID, 2'b01);
    chk("dec_s_arvalid", bus.S_AXI_ARVALID, 2'b00);
    drain();

    // slave AR stall then master R stall
    exp_ar.push_back('{0, 32'h0000_3000, 3'd2});
    exp_r.push_back('{0, d0, RESP_OKAY});
    bus.S_AXI_ARREADY[0] = 1'b0;
    issue(0, 32'h0000_3000, 3'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("bp_arvalid", bus.S_AXI_ARVALID, 2'b01);
      chk("bp_araddr", bus.S_AXI_ARADDR[31:0], 32'h0000_3000);
    end
    @(posedge aclk);
    #1;
    bus.S_AXI_ARREADY[0] = 1'b1;
    bus.M_AXI_RREADY[0]  = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.M_AXI_RVALID[0] && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("bp_rvalid_seen", bus.M_AXI_RVALID[0], 1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("bp_rvalid_hold", bus.M_AXI_RVALID, 2'b01);
      chk("bp_rdata_hold", bus.M_AXI_RDATA[31:0], d0);
    end
    @(posedge aclk);
    #1;
    bus.M_AXI_RREADY[0] = 1'b1;
    drain();

    // reset while in DATA; the response must never appear
    exp_ar.push_back('{0, 32'h0000_4000, 3'd3});
    bus.M_AXI_RREADY[0] = 1'b0;
    issue(0, 32'h0000_4000, 3'd3);
    begin
      int n;
      n = 0;
      while (!bus.M_AXI_RVALID[0] && n < 20) begin
        @(negedge aclk);
        n++;
      end
      chk("rst_in_data", bus.M_AXI_RVALID[0], 1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    bus.M_AXI_ARVALID = 2'b11;
    #1;
    chk("midrst_arready_req", bus.M_AXI_ARREADY, 0);
    bus.M_AXI_ARVALID = 2'b00;
    bus.M_AXI_RREADY  = 2'b11;
    repeat (2) @(posedge aclk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge aclk);
    #1;
    chk("post_rst_idle", bus.M_AXI_RVALID, 0);
    chk("post_rst_queue", exp_ar.size() + exp_r.size(), 0);

    // both masters request continuously; master 0 first after reset
    exp_ar.push_back('{0, 32'h0000_0100, 3'd1});
    exp_ar.push_back('{1, 32'h9000_0100, 3'd2});
    exp_ar.push_back('{0, 32'h0000_0200, 3'd1});
    exp_ar.push_back('{1, 32'h9000_0200, 3'd2});
    exp_r.push_back('{0, d0, RESP_OKAY});
    exp_r.push_back('{1, d1, RESP_SLVERR});
    exp_r.push_back('{0, d0, RESP_OKAY});
    exp_r.push_back('{1, d1, RESP_SLVERR});
    fork
      begin
        bus.M_AXI_ARADDR[31:0] = 32'h0000_0100;
        bus.M_AXI_ARPROT[2:0]  = 3'd1;
        bus.M_AXI_ARVALID[0]   = 1'b1;
        wait_grant(0);
        bus.M_AXI_ARADDR[31:0] = 32'h0000_0200;
        wait_grant(0);
        bus.M_AXI_ARVALID[0] = 1'b0;
      end
      begin
        bus.M_AXI_ARADDR[63:32] = 32'h9000_0100;
        bus.M_AXI_ARPROT[5:3]   = 3'd2;
        bus.M_AXI_ARVALID[1]    = 1'b1;
        wait_grant(1);
        bus.M_AXI_ARADDR[63:32] = 32'h9000_0200;
        wait_grant(1);
        bus.M_AXI_ARVALID[1] = 1'b0;
      end
    join
    drain();

    repeat (3) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
